// File: rtl/pipeline_ctrl.sv
// Pipeline latch controller: stalls, freezes, bubbles and flushes the five-stage
// pipeline from fetch/data handshakes and hazard-unit requests, and tracks halt.
module pipeline_ctrl (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        mem_dmemop,
    input  logic        lw_nop,
    input  logic        jmp_flush,
    input  logic        brch_flush,
    input  logic        halt_wb,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DWAIT  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        flush_pend_r;
    logic        flush_pend_nxt_s;
    logic        halted_r;
    logic [15:0] stall_cnt_r;

    logic        dwait_s;
    logic        adv_s;
    logic        flush_req_s;
    logic        active_s;
    logic        lw_stall_s;
    logic        stall_s;

    assign dwait_s     = mem_dmemop & ~dhit;
    assign adv_s       = ihit & ~dwait_s;
    assign flush_req_s = jmp_flush | brch_flush | flush_pend_r;
    assign active_s    = (state_r != ST_HALTED);
    // A load-use bubble only counts when no redirect overrides it.
    assign lw_stall_s  = adv_s & ~flush_req_s & lw_nop;
    assign stall_s     = active_s & (~adv_s | lw_stall_s);

    // Next-state and pending-flush bookkeeping.
    always_comb begin
        state_nxt_s      = state_r;
        flush_pend_nxt_s = flush_pend_r;
        case (state_r)
            ST_RUN, ST_DWAIT: begin
                if (adv_s && halt_wb) begin
                    state_nxt_s = ST_HALTED;
                end else if (dwait_s) begin
                    state_nxt_s = ST_DWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
                // A redirect that cannot be applied now is remembered until the pipe advances.
                if (adv_s) begin
                    flush_pend_nxt_s = 1'b0;
                end else begin
                    flush_pend_nxt_s = flush_req_s;
                end
            end
            ST_HALTED: begin
                state_nxt_s      = ST_HALTED;
                flush_pend_nxt_s = flush_pend_r;
            end
            default: begin
                state_nxt_s      = ST_RUN;
                flush_pend_nxt_s = 1'b0;
            end
        endcase
    end

    // Latch enables and bubble/flush controls.
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (RST) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (!active_s) begin
            pc_en = 1'b0;
        end else if (adv_s) begin
            ifid_en  = ~lw_stall_s;
            pc_en    = ~lw_stall_s;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (flush_req_s) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else begin
                idex_flush = lw_nop;
            end
        end else if (dwait_s) begin
            pc_en = 1'b0;
        end else begin
            // Fetch miss only: back half drains while a bubble enters ID/EX.
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            idex_flush = 1'b1;
        end
    end

    // State, pending flush, halt flag and stall counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= ST_RUN;
            flush_pend_r <= 1'b0;
            halted_r     <= 1'b0;
            stall_cnt_r  <= 16'd0;
        end else begin
            state_r      <= state_nxt_s;
            flush_pend_r <= flush_pend_nxt_s;
            halted_r     <= (state_nxt_s == ST_HALTED);
            if (stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + 16'd1;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign halted    = halted_r;
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal pins,
// randomized traffic against a rule-level model, and counter saturation.
module tb_pipeline_ctrl;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        ihit = 1'b0, dhit = 1'b0, mem_dmemop = 1'b0, lw_nop = 1'b0;
    logic        jmp_flush = 1'b0, brch_flush = 1'b0, halt_wb = 1'b0;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, halted;
    logic [15:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    // Model state: halted-or-not, pending redirect, stall count, registered halt flag.
    bit m_in_halt = 1'b0;
    bit m_pend    = 1'b0;
    int m_cnt     = 0;
    bit m_halted  = 1'b0;

    pipeline_ctrl dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dmemop(mem_dmemop),
        .lw_nop(lw_nop), .jmp_flush(jmp_flush), .brch_flush(brch_flush), .halt_wb(halt_wb),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, compare against the model, then advance the model.
    task automatic step(input bit r, input bit i, input bit d, input bit mo, input bit lw,
                        input bit j, input bit b, input bit h);
        bit   dw, adv, fr, stall;
        logic [6:0] exp_v, act_v;
        @(negedge CLK);
        RST = r; ihit = i; dhit = d; mem_dmemop = mo; lw_nop = lw;
        jmp_flush = j; brch_flush = b; halt_wb = h;
        #1;
        dw  = mo && !d;
        adv = i && !dw;
        fr  = j || b || m_pend;
        // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
        if (r)                  exp_v = 7'b0000011;
        else if (m_in_halt)     exp_v = 7'b0000000;
        else if (adv && fr)     exp_v = 7'b1111111;
        else if (adv && lw)     exp_v = 7'b0011101;
        else if (adv)           exp_v = 7'b1111100;
        else if (dw)            exp_v = 7'b0000000;
        else                    exp_v = 7'b0011101;
        act_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
        chk("ctrl_vec", {9'd0, act_v}, {9'd0, exp_v});
        chk("halted", {15'd0, halted}, {15'd0, m_halted});
        chk("stall_cnt", stall_cnt, m_cnt[15:0]);
        stall = !r && !m_in_halt && (!adv || (!fr && lw));
        if (r) begin
            m_in_halt = 1'b0; m_pend = 1'b0; m_cnt = 0; m_halted = 1'b0;
        end else if (!m_in_halt) begin
            m_pend = adv ? 1'b0 : fr;
            if (stall && m_cnt < 65535) m_cnt = m_cnt + 1;
            if (adv && h) m_in_halt = 1'b1;
            m_halted = m_in_halt;
        end else begin
            m_halted = 1'b1;
        end
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_ifid_flush", {15'd0, ifid_flush}, 16'd1);
        chk("rst_pc_en", {15'd0, pc_en}, 16'd0);
        // Normal run
        for (int k = 0; k < 4; k++) step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("run_pc_en", {15'd0, pc_en}, 16'd1);
        chk("run_cnt", stall_cnt, 16'd0);
        // Load-use bubble
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("lw_pc_en", {15'd0, pc_en}, 16'd0);
        chk("lw_idex_flush", {15'd0, idex_flush}, 16'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("lw_cnt", stall_cnt, 16'd1);
        // Deferred branch flush
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        chk("defer_ifid_flush", {15'd0, ifid_flush}, 16'd1);
        chk("defer_pc_en", {15'd0, pc_en}, 16'd1);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("defer_cleared", {15'd0, ifid_flush}, 16'd0);
        chk("defer_cnt", stall_cnt, 16'd3);
        // Data wait freeze
        for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 0, 0, 0, 0);
        chk("dwait_memwb_en", {15'd0, memwb_en}, 16'd0);
        step(0, 1, 1, 1, 0, 0, 0, 0);
        chk("dwait_release", {15'd0, memwb_en}, 16'd1);
        chk("dwait_cnt", stall_cnt, 16'd6);
        // Halt
        step(0, 1, 0, 0, 0, 0, 0, 1);
        chk("halt_retire_en", {15'd0, pc_en}, 16'd1);
        step(0, 1, 0, 0, 1, 1, 0, 0);
        chk("halted_flag", {15'd0, halted}, 16'd1);
        chk("halted_en", {15'd0, memwb_en}, 16'd0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("halted_cnt_hold", stall_cnt, 16'd6);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("halt_cleared", {15'd0, halted}, 16'd0);
        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0);
        end
        // Saturation, then reset with a pending flush
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 65540; k++) step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat_cnt", stall_cnt, 16'hFFFF);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("sat_hold", stall_cnt, 16'hFFFF);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("post_rst_ifid_flush", {15'd0, ifid_flush}, 16'd0);
        chk("post_rst_idex_flush", {15'd0, idex_flush}, 16'd0);
        chk("post_rst_cnt", stall_cnt, 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
